// File: rtl/dizy_stream_ctrl_pkg.sv
// Shared definitions for the DIZY stream controller.
//   - Core widths (state/key per share) and rand-bit width.
//   - LFSR polynomial, reset value and step/advance helpers.
//   - Controller FSM state encoding.
package dizy_stream_ctrl_pkg;

    localparam int unsigned DIZY_SIZE_STATE = 128;
    localparam int unsigned DIZY_SIZE_KEY   = 128;
    localparam int unsigned DIZY_RAND_W     = 20;

    localparam int unsigned LFSR_W     = 32;
    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
    localparam logic [31:0] LFSR_RESET = 32'h0000_0001;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StInitIssue = 3'd1,
        StInitWait  = 3'd2,
        StGenIssue  = 3'd3,
        StGenWait   = 3'd4
    } dizy_fsm_e;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    // One core rand request consumes DIZY_RAND_W fresh bits.
    function automatic logic [31:0] lfsr_advance(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < DIZY_RAND_W; i++) begin
            r = lfsr_step(r);
        end
        return r;
    endfunction

endpackage

// File: rtl/dizy_prng_lfsr.sv
// Rand-bit source for the masked DIZY core.
//   clk, rst    : clock, async active-high reset
//   seed_load   : load seed this cycle (a zero seed loads LFSR_RESET)
//   seed        : 32-bit seed
//   advance     : step the LFSR DIZY_RAND_W times
//   rand_bits   : low DIZY_RAND_W bits of the LFSR register
module dizy_prng_lfsr
    import dizy_stream_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   seed_load,
    input  logic [LFSR_W-1:0]      seed,
    input  logic                   advance,
    output logic [DIZY_RAND_W-1:0] rand_bits
);

    logic [LFSR_W-1:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_RESET;
        end else if (seed_load) begin
            // all-zero state would lock the LFSR
            lfsr_q <= (seed == '0) ? LFSR_RESET : seed;
        end else if (advance) begin
            lfsr_q <= lfsr_advance(lfsr_q);
        end
    end

    assign rand_bits = lfsr_q[DIZY_RAND_W-1:0];

endmodule

// File: rtl/dizy_stream_ctrl.sv
// Sequencer for the masked 1-round-per-cycle DIZY core.
//   Command side : cmd_valid/cmd_ready, cmd_init (1=INIT, 0=GEN), cmd_key_a/b, cmd_nblk,
//                  cmd_err (pulse: GEN before any INIT)
//   Seed         : seed_valid/seed, honoured in IDLE only
//   Output side  : out_valid/out_ready, out_a/b (state shares), out_last
//   Core side    : core_load/core_next, core_key_a/b, core_rand_bits, core_req_rand,
//                  core_busy, core_state_a/b
module dizy_stream_ctrl
    import dizy_stream_ctrl_pkg::*;
#(
    parameter int unsigned SIZE_STATE = DIZY_SIZE_STATE,
    parameter int unsigned SIZE_KEY   = DIZY_SIZE_KEY,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned SEED_W     = LFSR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_init,
    input  logic [SIZE_KEY-1:0]    cmd_key_a,
    input  logic [SIZE_KEY-1:0]    cmd_key_b,
    input  logic [CNT_W-1:0]       cmd_nblk,
    output logic                   cmd_err,
    input  logic                   seed_valid,
    input  logic [SEED_W-1:0]      seed,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SIZE_STATE-1:0]  out_a,
    output logic [SIZE_STATE-1:0]  out_b,
    output logic                   out_last,
    output logic                   core_load,
    output logic                   core_next,
    output logic [SIZE_KEY-1:0]    core_key_a,
    output logic [SIZE_KEY-1:0]    core_key_b,
    output logic [DIZY_RAND_W-1:0] core_rand_bits,
    input  logic                   core_req_rand,
    input  logic                   core_busy,
    input  logic [SIZE_STATE-1:0]  core_state_a,
    input  logic [SIZE_STATE-1:0]  core_state_b
);

    dizy_fsm_e             state_q;
    logic                  inited_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [SIZE_KEY-1:0]   key_a_q, key_b_q;
    logic [SIZE_STATE-1:0] out_a_q, out_b_q;
    logic                  out_valid_q, out_last_q;
    logic                  core_load_q, core_next_q, cmd_err_q;

    logic accept;
    logic out_pop;
    logic out_free;

    // The core has no reset: after a mid-run reset, wait out the orphaned run.
    assign cmd_ready = (state_q == StIdle) && !core_busy;
    assign accept    = cmd_valid && cmd_ready;
    assign out_pop   = out_valid_q && out_ready;
    assign out_free  = !out_valid_q || out_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            inited_q    <= 1'b0;
            cnt_q       <= '0;
            key_a_q     <= '0;
            key_b_q     <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            core_load_q <= 1'b0;
            core_next_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            core_load_q <= 1'b0;
            core_next_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            if (out_pop) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (accept) begin
                        key_a_q <= cmd_key_a;
                        key_b_q <= cmd_key_b;
                        if (cmd_init) begin
                            state_q     <= StInitIssue;
                            core_load_q <= 1'b1;
                        end else if (!inited_q) begin
                            cmd_err_q <= 1'b1;
                        end else if (cmd_nblk != '0) begin
                            cnt_q       <= cmd_nblk;
                            state_q     <= StGenIssue;
                            core_next_q <= 1'b1;
                        end
                    end
                end
                StInitIssue: state_q <= StInitWait;
                StInitWait: begin
                    // busy already high here: it rises on the edge that samples load
                    if (!core_busy) begin
                        inited_q <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                StGenIssue: state_q <= StGenWait;
                StGenWait: begin
                    // Core state is stable while idle, so holding here loses nothing.
                    if (!core_busy && out_free) begin
                        out_a_q     <= core_state_a;
                        out_b_q     <= core_state_b;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (cnt_q == CNT_W'(1));
                        cnt_q       <= cnt_q - CNT_W'(1);
                        if (cnt_q != CNT_W'(1)) begin
                            state_q     <= StGenIssue;
                            core_next_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_err    = cmd_err_q;
    assign out_valid  = out_valid_q;
    assign out_a      = out_a_q;
    assign out_b      = out_b_q;
    assign out_last   = out_last_q;
    assign core_load  = core_load_q;
    assign core_next  = core_next_q;
    assign core_key_a = key_a_q;
    assign core_key_b = key_b_q;

    dizy_prng_lfsr u_prng (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_valid && (state_q == StIdle)),
        .seed      (seed),
        .advance   (core_req_rand),
        .rand_bits (core_rand_bits)
    );

endmodule
